// File: rtl/psum_readout_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : psum_readout_if                                            |
// | Description : Row-capture bus plus psum streaming bus of psum_readout.   |
// |               slave = the readout block, master = its environment.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface psum_readout_if #(
  parameter int COL     = 8,
  parameter int BW_PSUM = 11
);
  localparam int CW = $clog2(COL);
  localparam int SW = BW_PSUM + CW;

  logic                     capture;
  logic [COL*BW_PSUM-1:0]   psum_in;
  logic                     cap_ready;
  logic                     overflow;
  logic                     o_valid;
  logic                     o_ready;
  logic signed [BW_PSUM-1:0] o_data;
  logic [CW-1:0]            o_col;
  logic                     o_last;
  logic signed [SW-1:0]     o_sum;

  modport slave (
    input  capture, psum_in, o_ready,
    output cap_ready, overflow, o_valid, o_data, o_col, o_last, o_sum
  );

  modport master (
    output capture, psum_in, o_ready,
    input  cap_ready, overflow, o_valid, o_data, o_col, o_last, o_sum
  );
endinterface
`default_nettype wire

// File: rtl/psum_readout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psum_readout                                               |
// | Description : Captures rows of signed psums (plus their row sum) into a  |
// |               small row FIFO and streams them out one psum per beat.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module psum_readout #(
  parameter int COL     = 8,
  parameter int BW_PSUM = 11,
  parameter int DEPTH   = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  psum_readout_if.slave   rd_if
);

  localparam int CW = $clog2(COL);
  localparam int SW = BW_PSUM + CW;
  localparam int PW = $clog2(DEPTH);
  localparam int RW = COL * BW_PSUM;
  localparam logic [PW:0]   PTR_ONE   = (PW+1)'(1);
  localparam logic [CW-1:0] BEAT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(COL - 1);

  // Row storage; each entry keeps the row and the sum computed at capture.
  logic [RW-1:0]        row_q [DEPTH];
  logic signed [SW-1:0] sum_q [DEPTH];

  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          overflow_q, overflow_d;

  logic [PW-1:0]        wr_idx, rd_idx;
  logic                 empty, full, last_beat;
  logic                 xfer, pop, push, cap_ready;
  logic signed [SW-1:0] row_sum;
  logic [BW_PSUM-1:0]   head_psum;

  assign wr_idx    = wr_ptr_q[PW-1:0];
  assign rd_idx    = rd_ptr_q[PW-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_idx == rd_idx) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign last_beat = (beat_q == LAST_BEAT);
  assign xfer      = !empty && rd_if.o_ready;
  assign pop       = xfer && last_beat;
  // A full FIFO can still take a row when the head row leaves this same cycle.
  assign cap_ready = !full || pop;
  assign push      = rd_if.capture && cap_ready;
  assign head_psum = row_q[rd_idx][beat_q*BW_PSUM +: BW_PSUM];

  // Sign-extended sum of the incoming row; the widened result cannot overflow.
  always_comb begin
    logic signed [BW_PSUM-1:0] p;
    row_sum = '0;
    for (int c = 0; c < COL; c++) begin
      p       = rd_if.psum_in[c*BW_PSUM +: BW_PSUM];
      row_sum = row_sum + SW'(p);
    end
  end

  // Next-state for pointers, beat counter and sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (xfer) begin
      if (last_beat) begin
        beat_d   = '0;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        beat_d = beat_q + BEAT_ONE;
      end
    end
    if (rd_if.capture && !cap_ready) begin
      overflow_d = 1'b1;
    end
  end

  // Control state register; reset discards every stored and partial row.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Row storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      row_q[wr_idx] <= rd_if.psum_in;
      sum_q[wr_idx] <= row_sum;
    end
  end

  // Data outputs read as zero while nothing is queued (so they are 0 after reset).
  assign rd_if.cap_ready = cap_ready;
  assign rd_if.overflow  = overflow_q;
  assign rd_if.o_valid   = !empty;
  assign rd_if.o_data    = empty ? '0 : head_psum;
  assign rd_if.o_col     = beat_q;
  assign rd_if.o_last    = !empty && last_beat;
  assign rd_if.o_sum     = empty ? '0 : sum_q[rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_psum_readout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_psum_readout                                            |
// | Description : Scoreboard bench for psum_readout: the driver queues the   |
// |               expected beats of every accepted row, a negedge monitor    |
// |               compares them against the streamed output.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_psum_readout;

  localparam int COL     = 8;
  localparam int BW_PSUM = 11;
  localparam int DEPTH   = 4;
  localparam int CW      = 3;
  localparam int SW      = BW_PSUM + CW;
  localparam int RW      = COL * BW_PSUM;

  typedef struct {
    logic signed [BW_PSUM-1:0] d;
    logic [CW-1:0]             c;
    logic                      last;
    logic signed [SW-1:0]      s;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    failures = 0;
  int    pend = 0;
  bit    model_ovf = 1'b0;
  beat_t exp_q[$];
  beat_t mb;

  psum_readout_if #(.COL(COL), .BW_PSUM(BW_PSUM)) bus ();

  psum_readout #(.COL(COL), .BW_PSUM(BW_PSUM), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .rd_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: act=%0d exp=%0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Row whose column c holds base + step*c.
  function automatic logic [RW-1:0] lin(input int base, input int stp);
    logic [RW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW_PSUM +: BW_PSUM] = BW_PSUM'(base + stp*c);
    return r;
  endfunction

  function automatic logic signed [SW-1:0] rowsum(input logic [RW-1:0] r);
    int acc = 0;
    logic signed [BW_PSUM-1:0] p;
    for (int c = 0; c < COL; c++) begin
      p   = r[c*BW_PSUM +: BW_PSUM];
      acc = acc + int'(p);
    end
    return SW'(acc);
  endfunction

  task automatic push_row(input logic [RW-1:0] r, input logic signed [SW-1:0] s);
    beat_t b;
    for (int c = 0; c < COL; c++) begin
      b.d    = r[c*BW_PSUM +: BW_PSUM];
      b.c    = CW'(c);
      b.last = (c == COL-1);
      b.s    = s;
      exp_q.push_back(b);
    end
    pend = COL;
  endtask

  // One cycle of stimulus; predicts cap_ready and acceptance from the model.
  task automatic step(input bit cap, input logic [RW-1:0] r, input logic signed [SW-1:0] s, input bit rdy);
    int rows;
    bit full, popnow, exp_rdy;
    @(posedge clk); #1;
    pend = 0;
    chk("overflow", bus.overflow, model_ovf);
    bus.capture = cap;
    bus.psum_in = r;
    bus.o_ready = rdy;
    #1;
    rows    = (exp_q.size() + COL - 1) / COL;
    full    = (rows == DEPTH);
    popnow  = rdy && (exp_q.size() > 0) && exp_q[0].last;
    exp_rdy = !full || popnow;
    chk("cap_ready", bus.cap_ready, exp_rdy);
    if (cap) begin
      if (exp_rdy) push_row(r, s);
      else         model_ovf = 1'b1;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy);
  endtask

  // Reset with a coincident capture that must be ignored, then check reset values.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.capture = 1'b1;
    bus.psum_in = lin(5, 1);
    bus.o_ready = 1'b1;
    exp_q.delete();
    pend = 0;
    model_ovf = 1'b0;
    @(posedge clk); #1;
    chk("rst_cap_ready", bus.cap_ready, 1);
    chk("rst_overflow",  bus.overflow,  0);
    chk("rst_o_valid",   bus.o_valid,   0);
    chk("rst_o_data",    bus.o_data,    0);
    chk("rst_o_col",     bus.o_col,     0);
    chk("rst_o_last",    bus.o_last,    0);
    chk("rst_o_sum",     bus.o_sum,     0);
    rst = 1'b0;
    bus.capture = 1'b0;
    bus.o_ready = 1'b0;
  endtask

  // Monitor: checks valid against the model every cycle and the head beat
  // (data, column, last, sum) whenever valid; pops on an accepted beat.
  always @(negedge clk) begin
    if (!rst) begin
      chk("o_valid", bus.o_valid, (exp_q.size() - pend) > 0);
      if (bus.o_valid && exp_q.size() > 0) begin
        mb = exp_q[0];
        chk("o_data", bus.o_data, mb.d);
        chk("o_col",  bus.o_col,  mb.c);
        chk("o_last", bus.o_last, mb.last);
        chk("o_sum",  bus.o_sum,  mb.s);
        if (bus.o_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [RW-1:0] rr;
    bus.capture = 1'b0;
    bus.psum_in = '0;
    bus.o_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single row 1..8, sum 36.
    step(1'b1, lin(1, 1), 36, 1'b1);
    idle(10, 1'b1);

    // All psums at the 11-bit minimum, sum -8192.
    step(1'b1, lin(-1024, 0), -8192, 1'b1);
    idle(10, 1'b1);

    // Backpressure: five rows into a four-deep FIFO, fifth dropped.
    for (int k = 1; k <= 5; k++) step(1'b1, lin(10*k, 1), SW'(80*k + 28), 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0);
    end
    idle(24, 1'b1);

    // Full FIFO, capture on the cycle the head row's last beat pops.
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, lin(10*k, 1), SW'(80*k + 28), 1'b0);
    idle(7, 1'b1);
    step(1'b1, lin(-300, 3), -2316, 1'b1);
    idle(34, 1'b1);

    // Reset while streaming, then a fresh row (sum 60).
    do_reset();
    step(1'b1, lin(1, 2), 64, 1'b1);
    step(1'b1, lin(-7, 1), -28, 1'b1);
    idle(2, 1'b1);
    do_reset();
    rr = lin(0, 0);
    rr[0*BW_PSUM +: BW_PSUM] = 11'd100;
    rr[1*BW_PSUM +: BW_PSUM] = -11'sd50;
    rr[2*BW_PSUM +: BW_PSUM] = 11'd7;
    rr[3*BW_PSUM +: BW_PSUM] = 11'd0;
    rr[4*BW_PSUM +: BW_PSUM] = -11'sd1;
    rr[5*BW_PSUM +: BW_PSUM] = 11'd1023;
    rr[6*BW_PSUM +: BW_PSUM] = -11'sd1024;
    rr[7*BW_PSUM +: BW_PSUM] = 11'd5;
    step(1'b1, rr, 60, 1'b1);
    idle(10, 1'b1);

    // Random capture / backpressure against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < COL; c++) rr[c*BW_PSUM +: BW_PSUM] = BW_PSUM'($urandom);
      step(bit'($urandom_range(0, 1)), rr, rowsum(rr), ($urandom_range(0, 9) < 6));
    end
    idle(40, 1'b1);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
